count_updn_mod: RTL
===================

Name: count_updn_mod

Overview:
- Parametrised synchronous up/down modulo counter; successor to the fixed 8-bit ripple counter.
- Adds configurable width and modulus, direction control, terminal-count flag and registered wrap pulse.
- Uses a single clock domain with no clock chaining, so it can be used as a timer/prescaler/address generator in larger datapaths.
- Parallel load of an arbitrary value is retained, with range checking.

Parameters:
- WIDTH, 8, counter width in bits; legal range is 2 to 32.
- MOD_MAX, 255, highest count value, inclusive. Legal range is 1 <= MOD_MAX <= 2^WIDTH-1. Count range is 0..MOD_MAX.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- res  input  1  synchronous reset, active-low
- EN  input  1  count enable
- load  input  1  synchronous parallel load
- up  input  1  direction; 1 = increment, 0 = decrement
- CNT_In  input  WIDTH  value to load
- CNT  output  WIDTH  current count, registered
- TC  output  1  terminal count, combinational from CNT and up
- OVF  output  1  wrap/limit pulse, registered

Behaviour:
- Reset is synchronous and active-low: clk rising edge with res=0 gives CNT=0 and OVF=0. The other inputs are ignored that cycle.
- Port names are clk and res. No asynchronous path exists on any flop.
- Priority per edge, highest first: res=0, then load=1, then EN=1, then hold.
- Load:
  - If CNT_In <= MOD_MAX, CNT takes CNT_In.
  - If CNT_In > MOD_MAX, CNT is clamped to MOD_MAX.
  - OVF is 0 that cycle.
  - EN and up are ignored.
- Count up (EN=1, up=1):
  - If CNT < MOD_MAX, CNT takes CNT+1 and OVF is 0.
  - If CNT == MOD_MAX, CNT wraps to 0 and OVF is 1.
- Count down (EN=1, up=0):
  - If CNT > 0, CNT takes CNT-1 and OVF is 0.
  - If CNT == 0, CNT wraps to MOD_MAX and OVF is 1.
- Hold (EN=0, load=0, res=1): CNT is unchanged and OVF is 0.
- OVF is a single-cycle pulse. It is high for exactly the cycle following the wrapping edge, and only wrap events set it.
- Latency: one clock from EN/load to the new CNT. TC follows CNT and up combinationally with zero latency.
- TC = (up & CNT==MOD_MAX) | (~up & CNT==0). TC is independent of EN.
- Direction change mid-count takes effect on the next enabled edge. There is no extra state.
- All arithmetic is unsigned, WIDTH bits. Intermediate +1 is computed in WIDTH+1 bits so MOD_MAX = 2^WIDTH-1 wraps correctly.
- Reset asserted mid-count takes effect on that edge; the wrap logic does not run that cycle.
- Structure: one WIDTH-bit register plus one OVF flop, with next-state logic in a single priority mux.

Optional Feature:
- Macro: COUNT_UPDN_SAT_EN.
- When defined, the counter saturates instead of wrapping:
  - Up at MOD_MAX holds MOD_MAX.
  - Down at 0 holds 0.
  - OVF is 1 on every enabled edge attempted while at the limit, so it can stay high over consecutive cycles.
  - TC is unchanged.
- When undefined: wrap behaviour exactly as described under Behaviour; no saturation logic is generated.

Test Plan:
- WIDTH=8, MOD_MAX=255. res=0 for 2 edges, then res=1, EN=1, up=1 for 256 edges: CNT goes 0,1,…,255,0. OVF is high only in the cycle after 255 becomes 0. TC=1 while CNT=255.
- WIDTH=4, MOD_MAX=9. load=1 with CNT_In=7, then EN=1, up=1 for 4 edges: CNT goes 7,8,9,0,1. OVF pulses once after 9 becomes 0.
- MOD_MAX=9, CNT=1, EN=1, up=0 for 3 edges: CNT goes 0,9,8. TC=1 at CNT=0. OVF pulses after 0 becomes 9.
- MOD_MAX=9. load=1 with CNT_In=13: CNT=9. Same edge with load=1, EN=1, up=1, CNT_In=3: CNT=3 (load wins).
- CNT=5, EN=1, load=1, res=0 on the same edge: CNT=0 and OVF=0. Then res=1, EN=0 for 3 edges: CNT stays 0.
- COUNT_UPDN_SAT_EN defined, MOD_MAX=9, CNT=8, EN=1, up=1 for 3 edges: CNT goes 9,9,9. OVF is 0,1,1.

Source files
------------

// File: rtl/count_updn_mod_if.sv
// Control/status bundle for count_updn_mod: the controller drives enable, load,
// direction and load value; the counter returns count, terminal count and wrap pulse.
interface count_updn_mod_if #(
    parameter int WIDTH = 8
);
    logic             EN;
    logic             load;
    logic             up;
    logic [WIDTH-1:0] CNT_In;
    logic [WIDTH-1:0] CNT;
    logic             TC;
    logic             OVF;

    modport master (
        output EN,
        output load,
        output up,
        output CNT_In,
        input  CNT,
        input  TC,
        input  OVF
    );

    modport slave (
        input  EN,
        input  load,
        input  up,
        input  CNT_In,
        output CNT,
        output TC,
        output OVF
    );
endinterface

// File: rtl/count_updn_mod.sv
// Up/down modulo counter over 0..MOD_MAX with clamped parallel load, terminal count and wrap pulse.
// Define COUNT_UPDN_SAT_EN to saturate at the limits instead of wrapping.
module count_updn_mod #(
    parameter int          WIDTH   = 8,
    parameter int unsigned MOD_MAX = 255
) (
    input  logic             clk,
    input  logic             res,
    count_updn_mod_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_MAX);

    logic [WIDTH-1:0] cnt_p0;
    logic             ovf_p0;
    logic [WIDTH-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             at_top;
    logic             at_bot;

    // Load values above the count range land on the top of the range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    // Extra carry bit keeps MOD_MAX = 2^WIDTH-1 well defined.
    function automatic logic [WIDTH-1:0] incr(input logic [WIDTH-1:0] v);
        logic [WIDTH:0] s;
        s = {1'b0, v} + (WIDTH+1)'(1);
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] decr(input logic [WIDTH-1:0] v);
        return v - WIDTH'(1);
    endfunction

    assign at_top = (cnt_p0 == MAX_V);
    assign at_bot = (cnt_p0 == '0);

    always_comb begin
        cnt_nxt = cnt_p0;
        ovf_nxt = 1'b0;
        if (bus.load) begin
            cnt_nxt = clamp_load(bus.CNT_In);
        end else if (bus.EN) begin
            if (bus.up) begin
                if (at_top) begin
                    ovf_nxt = 1'b1;
`ifdef COUNT_UPDN_SAT_EN
                    cnt_nxt = MAX_V;
`else
                    cnt_nxt = '0;
`endif
                end else begin
                    cnt_nxt = incr(cnt_p0);
                end
            end else begin
                if (at_bot) begin
                    ovf_nxt = 1'b1;
`ifdef COUNT_UPDN_SAT_EN
                    cnt_nxt = '0;
`else
                    cnt_nxt = MAX_V;
`endif
                end else begin
                    cnt_nxt = decr(cnt_p0);
                end
            end
        end
    end

    // Stage p0: count register and wrap flag
    always_ff @(posedge clk) begin
        if (!res) begin
            cnt_p0 <= '0;
            ovf_p0 <= 1'b0;
        end else begin
            cnt_p0 <= cnt_nxt;
            ovf_p0 <= ovf_nxt;
        end
    end

    assign bus.CNT = cnt_p0;
    assign bus.OVF = ovf_p0;
    assign bus.TC  = bus.up ? at_top : at_bot;
endmodule
